// File: rtl/priority_encoder_iter.sv
// Iterative priority encoder: accepts a request vector and emits each set bit
// as one handshaked beat (one-hot + index), LSB-first or MSB-first.
module priority_encoder_iter #(
   parameter  int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             mode_i,
   input  logic             data_val_i,
   output logic             data_rdy_o,
   output logic [WIDTH-1:0] onehot_o,
   output logic [IDX_W-1:0] index_o,
   output logic [IDX_W:0]   cnt_o,
   output logic             last_o,
   output logic             empty_o,
   output logic             data_val_o,
   input  logic             data_rdy_i
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_res;
   logic             r_dir;
   logic [IDX_W:0]   r_cnt;
   logic             r_empty;
   logic             r_rdy;

   logic [IDX_W-1:0] w_idx;
   logic [WIDTH-1:0] w_onehot;
   logic             w_single;
   logic             w_last;
   logic             w_accept;
   logic             w_xfer;

   function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
      logic [IDX_W:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + (IDX_W+1)'(v[i]);
      return c;
   endfunction

   // Last assignment wins: scanning toward the preferred end picks the winner.
   always_comb begin
      w_idx = '0;
      if (r_dir) begin
         for (int i = 0; i < WIDTH; i++)
            if (r_res[i]) w_idx = IDX_W'(i);
      end else begin
         for (int i = WIDTH-1; i >= 0; i--)
            if (r_res[i]) w_idx = IDX_W'(i);
      end
   end

   assign w_onehot = (|r_res) ? (WIDTH'(1) << w_idx) : '0;
   assign w_single = (|r_res) && ((r_res & (r_res - WIDTH'(1))) == '0);
   assign w_last   = r_empty || w_single;
   assign w_accept = (r_state == IDLE) && r_rdy && data_val_i;
   assign w_xfer   = (r_state == EMIT) && data_rdy_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = EMIT;
         EMIT:    if (w_xfer && w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ready is registered so it comes up only on the first edge after reset release.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_res   <= '0;
         r_dir   <= 1'b0;
         r_cnt   <= '0;
         r_empty <= 1'b0;
         r_rdy   <= 1'b0;
      end else begin
         r_rdy <= (w_next == IDLE);
         if (w_accept) begin
            r_res   <= data_i;
            r_dir   <= mode_i;
            r_cnt   <= popcnt(data_i);
            r_empty <= ~|data_i;
         end else if (w_xfer) begin
            r_res   <= r_res & ~w_onehot;
         end
      end
   end

   assign data_rdy_o = r_rdy;
   assign data_val_o = (r_state == EMIT);
   assign onehot_o   = w_onehot;
   assign index_o    = w_idx;
   assign cnt_o      = data_val_o ? r_cnt : '0;
   assign last_o     = data_val_o && w_last;
   assign empty_o    = data_val_o && r_empty;

endmodule
